// File: rtl/change_dispenser_if.sv
// change_dispenser_if: controller <-> coin dispenser bus (job request, refill, eject pulses, status, coin counts)
interface change_dispenser_if;
  logic       change_load;
  logic [7:0] change_amt;
  logic       refill;
  logic       coin5_out;
  logic       coin2_out;
  logic       coin1_out;
  logic       busy;
  logic       done;
  logic [7:0] shortfall;
  logic       short_flag;
  logic [3:0] cnt5;
  logic [3:0] cnt2;
  logic [3:0] cnt1;
  modport master (
    output change_load, change_amt, refill,
    input  coin5_out, coin2_out, coin1_out, busy, done, shortfall, short_flag, cnt5, cnt2, cnt1
  );
  modport slave (
    input  change_load, change_amt, refill,
    output coin5_out, coin2_out, coin1_out, busy, done, shortfall, short_flag, cnt5, cnt2, cnt1
  );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: greedy $5/$2/$1 coin ejector; clk/rst (async active-low) plus bus (slave): change_load/change_amt/refill in, coin pulses/busy/done/shortfall/short_flag/counts out
module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int INIT_COINS   = 8
) (
  input logic clk,
  input logic rst,
  change_dispenser_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;
  localparam logic [3:0] INIT       = 4'(INIT_COINS);
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
  state_t     state, state_nx;
  logic [7:0] remaining, shortfall, timer;
  logic [3:0] cnt5, cnt2, cnt1;
  logic [2:0] coin;
  logic       pick5, pick2, pick1;
  always_comb begin
    pick5    = remaining >= 8'd5 && cnt5 != 4'd0;
    pick2    = !pick5 && remaining >= 8'd2 && cnt2 != 4'd0;
    pick1    = !pick5 && !pick2 && remaining != 8'd0 && cnt1 != 4'd0;
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.change_load ? SELECT : IDLE;
      SELECT:  state_nx = (pick5 || pick2 || pick1) ? PULSE : DONE;
      PULSE:   state_nx = timer == 8'd0 ? GAP : PULSE;
      GAP:     state_nx = timer == 8'd0 ? SELECT : GAP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  // shortfall is captured on the edge into DONE so it is valid alongside done
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      remaining <= 8'd0;
      shortfall <= 8'd0;
      timer     <= 8'd0;
      coin      <= 3'd0;
      cnt5      <= INIT;
      cnt2      <= INIT;
      cnt1      <= INIT;
    end else begin
      case (state)
        IDLE: begin
          if (bus.refill) begin
            cnt5 <= INIT;
            cnt2 <= INIT;
            cnt1 <= INIT;
          end
          if (bus.change_load) remaining <= bus.change_amt;
        end
        SELECT: begin
          coin      <= {pick5, pick2, pick1};
          timer     <= PULSE_LAST;
          remaining <= remaining - (pick5 ? 8'd5 : pick2 ? 8'd2 : {7'd0, pick1});
          cnt5      <= cnt5 - {3'd0, pick5};
          cnt2      <= cnt2 - {3'd0, pick2};
          cnt1      <= cnt1 - {3'd0, pick1};
          if (!(pick5 || pick2 || pick1)) shortfall <= remaining;
        end
        PULSE:   timer <= timer == 8'd0 ? GAP_LAST : timer - 8'd1;
        GAP:     timer <= timer - 8'd1;
        default: ;
      endcase
    end
  // coin outputs decode from the registered state so reset drops them at once
  assign bus.coin5_out  = state == PULSE && coin[2];
  assign bus.coin2_out  = state == PULSE && coin[1];
  assign bus.coin1_out  = state == PULSE && coin[0];
  assign bus.busy       = state != IDLE;
  assign bus.done       = state == DONE;
  assign bus.shortfall  = shortfall;
  assign bus.short_flag = shortfall != 8'd0;
  assign bus.cnt5       = cnt5;
  assign bus.cnt2       = cnt2;
  assign bus.cnt1       = cnt1;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: table vectors, corner sequences and random jobs against a greedy arithmetic model
module tb_change_dispenser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  int m5[2], m2[2], m1[2];
  int init_c[2] = '{8, 1};
  int pc[2] = '{4, 2};
  int gc[2] = '{4, 1};
  typedef struct {
    bit         b;
    logic [7:0] amt;
    bit         rf;
    logic [7:0] sh;
    logic [11:0] cnts;
  } vec_t;
  vec_t tbl[9];
  change_dispenser_if ia();
  change_dispenser_if ib();
  change_dispenser dut_a (.clk(clk), .rst(rst), .bus(ia));
  change_dispenser #(.PULSE_CYCLES(2), .GAP_CYCLES(1), .INIT_COINS(1)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [4:0] obs(input bit b);
    return b ? {ib.coin5_out, ib.coin2_out, ib.coin1_out, ib.busy, ib.done}
             : {ia.coin5_out, ia.coin2_out, ia.coin1_out, ia.busy, ia.done};
  endfunction
  function automatic logic [7:0] sh(input bit b);
    return b ? ib.shortfall : ia.shortfall;
  endfunction
  function automatic logic flg(input bit b);
    return b ? ib.short_flag : ia.short_flag;
  endfunction
  function automatic logic [11:0] cnts(input bit b);
    return b ? {ib.cnt5, ib.cnt2, ib.cnt1} : {ia.cnt5, ia.cnt2, ia.cnt1};
  endfunction
  function automatic logic [11:0] model_cnts(input bit b);
    return {4'(m5[b]), 4'(m2[b]), 4'(m1[b])};
  endfunction
  function automatic int mn(input int x, input int y);
    return x < y ? x : y;
  endfunction
  task automatic set_in(input bit b, input logic ld, input logic [7:0] amt, input logic rf);
    if (b) begin
      ib.change_load = ld;
      ib.change_amt  = amt;
      ib.refill      = rf;
    end else begin
      ia.change_load = ld;
      ia.change_amt  = amt;
      ia.refill      = rf;
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m5[i] = init_c[i];
      m2[i] = init_c[i];
      m1[i] = init_c[i];
    end
  endtask
  // Called away from a rising edge with the DUT idle. Expected waveform is derived
  // from coin counts: coin i occupies edges i*T+1..i*T+T, high for the first P of them.
  task automatic run_job(input bit b, input logic [7:0] amt, input bit rf, input bit disturb);
    int r, n5, n2, n1, n, t, i, v;
    logic [4:0] e;
    if (rf) begin
      m5[b] = init_c[b];
      m2[b] = init_c[b];
      m1[b] = init_c[b];
    end
    r  = int'(amt);
    n5 = mn(r / 5, m5[b]);
    r -= 5 * n5;
    n2 = mn(r / 2, m2[b]);
    r -= 2 * n2;
    n1 = mn(r, m1[b]);
    r -= n1;
    n  = n5 + n2 + n1;
    t  = 1 + pc[b] + gc[b];
    set_in(b, 1'b1, amt, rf);
    @(posedge clk);
    #1;
    set_in(b, 1'b0, 8'd0, 1'b0);
    for (int k = 0; k <= n * t + 2; k++) begin
      @(negedge clk);
      e = {3'b000, k <= n * t + 1, k == n * t + 1};
      if (k >= 1 && k <= n * t && (k - 1) % t < pc[b]) begin
        i = (k - 1) / t;
        v = i < n5 ? 5 : i < n5 + n2 ? 2 : 1;
        e[4] = v == 5;
        e[3] = v == 2;
        e[2] = v == 1;
      end
      chk("wave", 32'(obs(b)), 32'(e));
      if (disturb && k == pc[b] + 1) set_in(b, 1'b1, 8'd5, 1'b1);
      else if (disturb && k == pc[b] + 2) set_in(b, 1'b0, 8'd0, 1'b0);
    end
    m5[b] -= n5;
    m2[b] -= n2;
    m1[b] -= n1;
    chk("shortfall", 32'(sh(b)), 32'(r));
    chk("short_flag", 32'(flg(b)), 32'(r != 0));
    chk("counts", 32'(cnts(b)), 32'(model_cnts(b)));
  endtask
  initial begin
    bit rb;
    int op;
    set_in(1'b0, 1'b0, 8'd0, 1'b0);
    set_in(1'b1, 1'b0, 8'd0, 1'b0);
    tbl[0] = '{1'b0, 8'd8,   1'b0, 8'd0,   12'h777};
    tbl[1] = '{1'b0, 8'd0,   1'b0, 8'd0,   12'h777};
    tbl[2] = '{1'b1, 8'd9,   1'b0, 8'd1,   12'h000};
    tbl[3] = '{1'b1, 8'd0,   1'b1, 8'd0,   12'h111};
    tbl[4] = '{1'b1, 8'd3,   1'b0, 8'd0,   12'h100};
    tbl[5] = '{1'b1, 8'd7,   1'b0, 8'd2,   12'h000};
    tbl[6] = '{1'b0, 8'd255, 1'b1, 8'd191, 12'h000};
    tbl[7] = '{1'b0, 8'd4,   1'b0, 8'd4,   12'h000};
    tbl[8] = '{1'b0, 8'd6,   1'b1, 8'd0,   12'h787};
    model_reset();
    #2 rst = 1'b0;
    #1;
    chk("async_rst_outs", 32'(obs(0)), 32'd0);
    chk("async_rst_cnts", 32'(cnts(0)), 32'h888);
    repeat (3) @(negedge clk);
    chk("rst_outs_a", 32'(obs(0)), 32'd0);
    chk("rst_outs_b", 32'(obs(1)), 32'd0);
    chk("rst_short", 32'({sh(0), flg(0)}), 32'd0);
    chk("rst_cnts_a", 32'(cnts(0)), 32'h888);
    chk("rst_cnts_b", 32'(cnts(1)), 32'h111);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_hold_outs", 32'(obs(0)), 32'd0);
    chk("idle_hold_cnts", 32'(cnts(0)), 32'h888);
    for (int i = 0; i < 9; i++) begin
      run_job(tbl[i].b, tbl[i].amt, tbl[i].rf, 1'b0);
      chk("tbl_short", 32'(sh(tbl[i].b)), 32'(tbl[i].sh));
      chk("tbl_flag", 32'(flg(tbl[i].b)), 32'(tbl[i].sh != 8'd0));
      chk("tbl_cnts", 32'(cnts(tbl[i].b)), 32'(tbl[i].cnts));
    end
    run_job(1'b0, 8'd8, 1'b0, 1'b1);
    chk("disturb_cnts", 32'(cnts(0)), 32'h676);
    set_in(1'b0, 1'b1, 8'd8, 1'b0);
    @(posedge clk);
    #1;
    set_in(1'b0, 1'b0, 8'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pulse_before_rst", 32'(ia.coin5_out), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid_pulse_outs", 32'(obs(0)), 32'd0);
    chk("rst_mid_pulse_cnts", 32'(cnts(0)), 32'h888);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_resume", 32'(obs(0)), 32'd0);
    end
    run_job(1'b0, 8'd2, 1'b0, 1'b0);
    for (int j = 0; j < 40; j++) begin
      rb = 1'($urandom_range(0, 1));
      op = int'($urandom_range(0, 5));
      if (op == 0) begin
        set_in(rb, 1'b0, 8'd0, 1'b1);
        @(negedge clk);
        set_in(rb, 1'b0, 8'd0, 1'b0);
        m5[rb] = init_c[rb];
        m2[rb] = init_c[rb];
        m1[rb] = init_c[rb];
        chk("refill_idle", 32'(cnts(rb)), 32'(model_cnts(rb)));
      end else begin
        run_job(rb, 8'($urandom_range(0, 40)), $urandom_range(0, 3) == 0, 1'b0);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
